// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode trap entry / MRET sequencer owning the CSR port while stalled
// Optional interrupt detection is enabled by defining CSR_TRAP_IRQ_EN.
module csr_trap_ctrl #(
    parameter logic [11:0] EPC_ADDR    = 12'h341,
    parameter logic [11:0] CAUSE_ADDR  = 12'h342,
    parameter logic [11:0] STATUS_ADDR = 12'h300,
    parameter logic [11:0] TVEC_ADDR   = 12'h305
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [11:0] f12,
    input  logic [31:0] pc,
    input  logic        irq,
    input  logic        mie,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_we,
    output logic        trap_csr_sel,
    output logic        stall,
    output logic        pc_load,
    output logic [31:0] pc_target
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_SAVE_EPC    = 3'd1;
    localparam logic [2:0] S_SAVE_CAUSE  = 3'd2;
    localparam logic [2:0] S_SAVE_STATUS = 3'd3;
    localparam logic [2:0] S_VECTOR      = 3'd4;
    localparam logic [2:0] S_RET_STATUS  = 3'd5;
    localparam logic [2:0] S_RET_PC      = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, cause_q;
    logic        is_sys, irq_take, take_trap, go_ret, idle;
    logic [31:0] trap_cause;
    logic [11:0] addr_c;
    logic [31:0] wdata_c, target_c;
    logic        we_c, load_c;

`ifdef CSR_TRAP_IRQ_EN
    assign irq_take = irq & mie;
`else
    logic unused_irq;
    assign unused_irq = irq & mie;
    assign irq_take   = 1'b0;
`endif

    assign idle      = (state_q == S_IDLE);
    assign is_sys    = inst_valid && (op == 7'h73) && (f3 == 3'b000);
    // An interrupt preempts whatever instruction sits in decode that cycle.
    assign take_trap = idle && (irq_take || (is_sys && (f12 == 12'h000 || f12 == 12'h001)));
    assign go_ret    = idle && !irq_take && is_sys && (f12 == 12'h302);
    assign trap_cause = irq_take         ? 32'h8000_000B :
                        (f12 == 12'h001) ? 32'd3 : 32'd11;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                epc_q   <= pc;
                cause_q <= trap_cause;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_c   = 12'h0;
        wdata_c  = 32'h0;
        we_c     = 1'b0;
        load_c   = 1'b0;
        target_c = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (take_trap)   state_d = S_SAVE_EPC;
                else if (go_ret) state_d = S_RET_STATUS;
            end
            S_SAVE_EPC: begin
                addr_c  = EPC_ADDR;
                wdata_c = epc_q;
                we_c    = 1'b1;
                state_d = S_SAVE_CAUSE;
            end
            S_SAVE_CAUSE: begin
                addr_c  = CAUSE_ADDR;
                wdata_c = cause_q;
                we_c    = 1'b1;
                state_d = S_SAVE_STATUS;
            end
            S_SAVE_STATUS: begin
                addr_c     = STATUS_ADDR;
                wdata_c    = csr_rdata;
                wdata_c[7] = csr_rdata[3];
                wdata_c[3] = 1'b0;
                we_c       = 1'b1;
                state_d    = S_VECTOR;
            end
            S_VECTOR: begin
                addr_c   = TVEC_ADDR;
                load_c   = 1'b1;
                target_c = {csr_rdata[31:2], 2'b00};
                state_d  = S_IDLE;
            end
            S_RET_STATUS: begin
                addr_c     = STATUS_ADDR;
                wdata_c    = csr_rdata;
                wdata_c[3] = csr_rdata[7];
                wdata_c[7] = 1'b1;
                we_c       = 1'b1;
                state_d    = S_RET_PC;
            end
            S_RET_PC: begin
                addr_c   = EPC_ADDR;
                load_c   = 1'b1;
                target_c = {csr_rdata[31:2], 2'b00};
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with rst_n keeps every output quiet during reset, even mid-sequence.
    assign csr_addr     = rst_n ? addr_c   : 12'h0;
    assign csr_wdata    = rst_n ? wdata_c  : 32'h0;
    assign csr_we       = rst_n & we_c;
    assign pc_load      = rst_n & load_c;
    assign pc_target    = rst_n ? target_c : 32'h0;
    assign trap_csr_sel = rst_n & !idle;
    assign stall        = rst_n & (!idle | take_trap | go_ret);

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Multi-cycle trap and return sequencer for the rv32i core's machine-mode CSR file. It detects ECALL, EBREAK, MRET and, optionally, a pending external interrupt, then stalls the pipeline. While stalled it owns the CSR file's single read/write port and updates mepc, mcause and mstatus over successive cycles. It finishes by issuing a PC redirect to mtvec (trap entry) or mepc (return). It sits beside the CSR decoder, between the decode stage and the CSR file, and shares the CSR port with normal CSRRW/CSRRWI traffic through `trap_csr_sel`.

## Interface
Parameters:
- `EPC_ADDR`, 12'h341, mepc address
- `CAUSE_ADDR`, 12'h342, mcause address
- `STATUS_ADDR`, 12'h300, mstatus address
- `TVEC_ADDR`, 12'h305, mtvec address

Ports:
- `clk`  in  1  core clock; one clock domain, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `inst_valid`  in  1  decode-stage instruction valid
- `op`  in  7  instr[6:0]
- `f3`  in  3  instr[14:12]
- `f12`  in  12  instr[31:20]
- `pc`  in  32  PC of the decode-stage instruction
- `irq`  in  1  external machine interrupt, level
- `mie`  in  1  mstatus.MIE from the CSR file
- `csr_rdata`  in  32  combinational CSR read data for `csr_addr`
- `csr_addr`  out  12  CSR address while the controller owns the port
- `csr_wdata`  out  32  CSR write data
- `csr_we`  out  1  CSR write strobe
- `trap_csr_sel`  out  1  1 means the CSR port mux selects this block
- `stall`  out  1  freeze fetch/decode, suppress regfile/memory writes
- `pc_load`  out  1  one-cycle PC redirect strobe
- `pc_target`  out  32  redirect target, word aligned

## Operation
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, VECTOR, RET_STATUS, RET_PC.
- Decode, evaluated in IDLE only, with `inst_valid`=1, `op`=7'h73 and `f3`=0:
  - `f12`=12'h000: ECALL, cause 32'd11.
  - `f12`=12'h001: EBREAK, cause 32'd3.
  - `f12`=12'h302: MRET.
  - Any other `f12`: no action.
- Interrupt (IRQ_EN only): `irq`=1 and `mie`=1 in IDLE gives cause 32'h8000000B.
  - Priority over any instruction in the same cycle; that instruction is not executed.
- Trap detect in IDLE:
  - Latch epc_q <= `pc` and cause_q.
  - Go to SAVE_EPC. MRET goes to RET_STATUS instead.
- SAVE_EPC: `csr_addr`=EPC_ADDR, `csr_wdata`=epc_q, `csr_we`=1, then SAVE_CAUSE.
- SAVE_CAUSE: `csr_addr`=CAUSE_ADDR, `csr_wdata`=cause_q, `csr_we`=1, then SAVE_STATUS.
- SAVE_STATUS: `csr_addr`=STATUS_ADDR, `csr_we`=1, then VECTOR.
  - `csr_wdata` = `csr_rdata` with bit7 (MPIE) <= bit3 and bit3 (MIE) <= 0.
- VECTOR: `csr_addr`=TVEC_ADDR, `csr_we`=0, `pc_load`=1, `pc_target`={`csr_rdata`[31:2],2'b00}, then IDLE.
  - Direct mode only; mtvec[1:0] is ignored.
- RET_STATUS: `csr_addr`=STATUS_ADDR, `csr_we`=1, then RET_PC.
  - `csr_wdata` = `csr_rdata` with bit3 <= bit7 and bit7 <= 1.
- RET_PC: `csr_addr`=EPC_ADDR, `csr_we`=0, `pc_load`=1, `pc_target`={`csr_rdata`[31:2],2'b00}, then IDLE.
- Output decode:
  - `trap_csr_sel`=1 in every non-IDLE state.
  - `stall`=1 in every non-IDLE state, and combinationally in the IDLE detect cycle.
  - In IDLE, `csr_addr`, `csr_wdata`, `csr_we`, `pc_load` and `pc_target` are all 0.
- `inst_valid` and `irq` are ignored outside IDLE.
- epc_q and cause_q hold until the next detect.

## Timing
- Reset (`rst_n`=0 at a rising edge) puts the FSM in IDLE and clears epc_q and cause_q to 0.
  - All outputs are 0 while in reset, including `stall`.
- Reset mid-sequence aborts at once; no further CSR writes are issued.
- Trap entry:
  - Detect cycle T, then writes at T+1 (mepc), T+2 (mcause), T+3 (mstatus).
  - `pc_load` at T+4; IDLE at T+5. `stall` is high T..T+4.
- MRET:
  - Detect at T, mstatus write at T+1, `pc_load` at T+2, IDLE at T+3.
  - `stall` is high T..T+2.
- Back-to-back: a new detect is allowed in the first IDLE cycle after `pc_load`.
  - Example: an interrupt taken right after MRET re-enables MIE.
- `pc_load` is exactly one cycle wide; `csr_we` is never high in IDLE.

## Configuration
- `CSR_TRAP_IRQ_EN` defined: interrupt detection is active as described above.
- `CSR_TRAP_IRQ_EN` undefined: `irq` is ignored (port kept); only ECALL, EBREAK and MRET are sequenced.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles during SAVE_CAUSE -> all outputs 0, FSM in IDLE, no `csr_we` after reset.
- ECALL at `pc`=0x100 with mtvec=0x2003 and mstatus=0x8:
  - Writes mepc=0x100 at T+1, mcause=11 at T+2, mstatus=0x80 at T+3.
  - `pc_load` with `pc_target`=0x2000 at T+4; `stall` high for 5 cycles.
- EBREAK at `pc`=0x44 -> mcause=3, mepc=0x44; sequence otherwise identical to ECALL.
- MRET with mepc=0x104 and mstatus=0x80:
  - mstatus write 0x88 at T+1.
  - `pc_load` with `pc_target`=0x104 at T+2; `stall` high for 3 cycles.
- IRQ_EN: `irq`=1 and `mie`=1 in the same cycle as an ECALL at 0x200:
  - mcause=0x8000000B, mepc=0x200.
  - With `mie`=0 no trap is taken; with the macro undefined no trap is taken.
- Busy ignore: pulse ECALL and `irq` during SAVE_EPC -> no extra sequence; `pc_load` occurs once.
